alu_result_writeback: RTL

Write-back sequencer at the consumer end of the main ALU result interface. Accepts one {Result, Overflow, ALUControl, destinations} packet per cycle over a valid/ready handshake, buffers packets in a small FIFO, and drains them onto the single register-file write port. SWAP packets are split into two consecutive writes. Signed-overflow ADD/SUB packets raise a one-cycle exception instead of writing.

---
 rtl/alu_result_writeback_pkg.sv | 28 ++
 rtl/alu_result_writeback_if.sv | 23 ++
 rtl/alu_result_writeback_wb_fifo.sv | 56 +++++
 rtl/alu_result_writeback.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_result_writeback_pkg.sv
// Shared types for the ALU result write-back sequencer: opcode constants,
// the buffered packet layout and the drain-state encoding.
package alu_result_writeback_pkg;

    // Register address width carried inside each buffered packet.
    localparam int WB_REG_AW = 4;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MOVE = 3'b010;
    localparam logic [2:0] ALU_SWAP = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;

    typedef struct packed {
        logic [31:0]          result;
        logic                 overflow;
        logic [2:0]           opcode;
        logic [WB_REG_AW-1:0] dest_a;
        logic [WB_REG_AW-1:0] dest_b;
    } wb_entry_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SWAP_HI = 1'b1
    } drain_state_t;

endpackage

// File: rtl/alu_result_writeback_if.sv
// Producer-to-write-back handshake bundle. The producer (master) holds a
// packet on InValid until InReady is seen high at a clock edge.
interface alu_result_writeback_if #(
    parameter int REG_AW = 4
) ();
    logic              InValid;
    logic              InReady;
    logic [31:0]       InResult;
    logic              InOverflow;
    logic [2:0]        InALUControl;
    logic [REG_AW-1:0] InDestA;
    logic [REG_AW-1:0] InDestB;

    modport master (
        output InValid, InResult, InOverflow, InALUControl, InDestA, InDestB,
        input  InReady
    );

    modport slave (
        input  InValid, InResult, InOverflow, InALUControl, InDestA, InDestB,
        output InReady
    );
endinterface

// File: rtl/alu_result_writeback_wb_fifo.sv
// Synchronous FIFO of write-back packets. Head is read combinationally so the
// drain FSM can act on a packet in the cycle after it was pushed.
module wb_fifo
    import alu_result_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_entry_t                din,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_writeback.sv
// ALU result write-back sequencer: buffers result packets and drains them onto
// the single register-file write port, splitting SWAP into two writes.
// Build option: define WB_OVERFLOW_TRAP_EN to turn overflowing ADD/SUB into a
// one-cycle Exception pulse instead of a write; otherwise they write normally
// and Exception/ExcDest stay 0.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | act on FIFO head: single write, trap, or low half of a SWAP
// ST_SWAP_HI | write high half of the SWAP at the head, then pop it
module alu_result_writeback
    import alu_result_writeback_pkg::*;
#(
    parameter int DEPTH  = 4,
    // Must match WB_REG_AW, the destination width stored in each packet.
    parameter int REG_AW = WB_REG_AW
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    alu_result_writeback_if.slave in_bus,
    output logic                  RegWrEn,
    output logic [REG_AW-1:0]     RegWrAddr,
    output logic [15:0]           RegWrData,
    output logic                  Exception,
    output logic [REG_AW-1:0]     ExcDest,
    output logic                  Busy
);
    localparam int CW = $clog2(DEPTH) + 1;

`ifdef WB_OVERFLOW_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    drain_state_t      state_q;
    drain_state_t      state_d;
    wb_entry_t         fifo_din;
    wb_entry_t         head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     count_next;
    logic              push;
    logic              pop;

    logic              wr_en_d;
    logic [REG_AW-1:0] wr_addr_d;
    logic [15:0]       wr_data_d;
    logic              exc_d;
    logic [REG_AW-1:0] exc_dest_d;

    // Ready comes from the pre-pop count, so a full FIFO refuses a push even
    // in the cycle it pops.
    assign in_bus.InReady = !fifo_full;
    assign push           = in_bus.InValid && in_bus.InReady;

    assign fifo_din.result   = in_bus.InResult;
    assign fifo_din.overflow = in_bus.InOverflow;
    assign fifo_din.opcode   = in_bus.InALUControl;
    assign fifo_din.dest_a   = in_bus.InDestA;
    assign fifo_din.dest_b   = in_bus.InDestB;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Reset_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A SWAP stays at the head during SWAP_HI, so occupancy alone tells Busy.
    assign count_next = fifo_count + CW'(push) - CW'(pop);

    // Drain decision for the current head: next state, pop and next outputs.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        exc_d      = 1'b0;
        exc_dest_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    case (head.opcode)
                        ALU_SWAP: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = head.dest_a;
                            wr_data_d = head.result[15:0];
                            state_d   = ST_SWAP_HI;
                        end
                        ALU_ADD, ALU_SUB: begin
                            pop = 1'b1;
                            if (TRAP_EN && head.overflow) begin
                                exc_d      = 1'b1;
                                exc_dest_d = head.dest_a;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = head.dest_a;
                                wr_data_d = head.result[15:0];
                            end
                        end
                        ALU_MOVE, ALU_AND, ALU_OR: begin
                            pop       = 1'b1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = head.dest_a;
                            wr_data_d = head.result[15:0];
                        end
                        default: begin
                            // 110/111 decode as OR.
                            pop       = 1'b1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = head.dest_a;
                            wr_data_d = head.result[15:0];
                        end
                    endcase
                end
            end
            ST_SWAP_HI: begin
                pop       = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = head.dest_b;
                wr_data_d = head.result[31:16];
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered write-port / exception / busy outputs.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            RegWrEn   <= 1'b0;
            RegWrAddr <= '0;
            RegWrData <= '0;
            Exception <= 1'b0;
            ExcDest   <= '0;
            Busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            RegWrEn   <= wr_en_d;
            RegWrAddr <= wr_addr_d;
            RegWrData <= wr_data_d;
            Exception <= exc_d;
            ExcDest   <= exc_dest_d;
            Busy      <= (count_next != '0);
        end
    end

endmodule
